// File: rtl/uart_reg_bridge_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the UART
// register bridge.
package uart_bridge_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, BUS_WR, BUS_RD, RESP, RESP_WAIT
  } bridge_state_t;

  // Only 'W' and 'R' open a command; everything else is answered with NAK.
  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WR) || (b == OP_RD);
  endfunction

endpackage

// File: rtl/uart_reg_bridge_if.sv
// UART byte handshake plus register bus, seen from the bridge (master)
// and from the UART/register side (slave).
interface uart_reg_bridge_if #(
  parameter int ADDR_WIDTH = 16
) ();
  logic [7:0]            rx_data;
  logic                  rx_done;
  logic [7:0]            tx_data;
  logic                  tx_en;
  logic                  tx_busy;
  logic                  tx_done;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [7:0]            bus_wdata;
  logic                  bus_we;
  logic                  bus_re;
  logic [7:0]            bus_rdata;
  logic                  bus_rvalid;

  modport master (
    input  rx_data, rx_done, tx_busy, tx_done, bus_rdata, bus_rvalid,
    output tx_data, tx_en, bus_addr, bus_wdata, bus_we, bus_re
  );

  modport slave (
    output rx_data, rx_done, tx_busy, tx_done, bus_rdata, bus_rvalid,
    input  tx_data, tx_en, bus_addr, bus_wdata, bus_we, bus_re
  );
endinterface

// File: rtl/uart_reg_bridge_timeout.sv
// Idle watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the TIMEOUT_CYC-th enabled cycle is reached.
module bridge_timeout #(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int TO_BITS     = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [TO_BITS-1:0] cnt;

  // Count up while enabled; the owner clears on every byte and state change.
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (enable)  cnt <= cnt + TO_BITS'(1);
  end

  assign expired = enable && (cnt == TO_BITS'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/uart_reg_bridge.sv
// UART command responder: decodes 'W'/'R' commands from RX bytes, performs
// one register-bus access and returns exactly one response byte on TX.
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int ADDR_BYTES  = 2,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int TO_BITS     = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  uart_reg_bridge_if.master bif,
  output logic              cmd_active
);
  localparam int ADDR_WIDTH = 8 * ADDR_BYTES;
  localparam int CNT_W      = $clog2(ADDR_BYTES + 1);

  bridge_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            wdata_q, rsp_q;
  logic [CNT_W-1:0]      byte_cnt;
  logic                  is_wr, re_sent, last_addr;
  logic                  to_clear, to_en, to_exp;
  logic                  bus_we, bus_re, tx_en;

  assign last_addr = (byte_cnt == CNT_W'(ADDR_BYTES - 1));
  assign to_en     = (state_q == ADDR) || (state_q == DATA) || (state_q == BUS_RD);
  assign to_clear  = bif.rx_done || (state_d != state_q);

  bridge_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_BITS(TO_BITS)) u_to (
    .clk     (clk),
    .rst     (rst),
    .clear   (to_clear),
    .enable  (to_en),
    .expired (to_exp)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and single-cycle strobes; a byte arriving in the same cycle
  // as the timeout takes priority because it is tested first.
  always_comb begin
    state_d = state_q;
    bus_we  = 1'b0;
    bus_re  = 1'b0;
    tx_en   = 1'b0;
    unique case (state_q)
      IDLE:      if (bif.rx_done) state_d = is_opcode(bif.rx_data) ? ADDR : RESP;
      ADDR: begin
        if (bif.rx_done) begin
          if (last_addr) state_d = is_wr ? DATA : BUS_RD;
        end else if (to_exp) state_d = IDLE;
      end
      DATA: begin
        if (bif.rx_done)  state_d = BUS_WR;
        else if (to_exp)  state_d = IDLE;
      end
      BUS_WR: begin
        bus_we  = 1'b1;
        state_d = RESP;
      end
      BUS_RD: begin
        bus_re = !re_sent;
        if (bif.bus_rvalid || to_exp) state_d = RESP;
      end
      RESP: begin
        if (!bif.tx_busy) begin
          tx_en   = 1'b1;
          state_d = RESP_WAIT;
        end
      end
      RESP_WAIT: if (bif.tx_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Command datapath: address shift, write data, response byte, activity flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_q      <= '0;
      byte_cnt   <= '0;
      is_wr      <= 1'b0;
      re_sent    <= 1'b0;
      cmd_active <= 1'b0;
    end else begin
      re_sent <= (state_q == BUS_RD);
      case (state_q)
        IDLE: if (bif.rx_done) begin
          byte_cnt   <= '0;
          is_wr      <= (bif.rx_data == OP_WR);
          cmd_active <= is_opcode(bif.rx_data);
          if (!is_opcode(bif.rx_data)) rsp_q <= RSP_NAK;
        end
        ADDR: begin
          if (bif.rx_done) begin
            addr_q   <= ADDR_WIDTH'({addr_q, bif.rx_data});
            byte_cnt <= byte_cnt + CNT_W'(1);
          end else if (to_exp) cmd_active <= 1'b0;
        end
        DATA: begin
          if (bif.rx_done)  wdata_q    <= bif.rx_data;
          else if (to_exp)  cmd_active <= 1'b0;
        end
        BUS_WR: rsp_q <= RSP_ACK;
        BUS_RD: begin
          if (bif.bus_rvalid) rsp_q <= bif.bus_rdata;
          else if (to_exp)    rsp_q <= RSP_NAK;
        end
        RESP_WAIT: if (bif.tx_done) cmd_active <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bif.bus_we    = bus_we;
  assign bif.bus_re    = bus_re;
  assign bif.tx_en     = tx_en;
  assign bif.tx_data   = rsp_q;
  assign bif.bus_addr  = addr_q;
  assign bif.bus_wdata = wdata_q;
endmodule

// File: tb/tb_uart_reg_bridge.sv
// Self-checking bench for uart_reg_bridge: UART TX model, register-bus
// responder and a command-level reference model of expected responses.
module tb_uart_reg_bridge;
  localparam int         TO     = 64;
  localparam logic [7:0] C_W    = 8'h57;
  localparam logic [7:0] C_R    = 8'h52;
  localparam logic [7:0] C_ACK  = 8'h06;
  localparam logic [7:0] C_NAK  = 8'h15;

  logic clk = 1'b0;
  logic rst;
  logic cmd_active;
  int   cyc = 0;

  uart_reg_bridge_if #(.ADDR_WIDTH(16)) bif ();

  uart_reg_bridge #(.ADDR_BYTES(2), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .bif        (bif.master),
    .cmd_active (cmd_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Environment state
  logic [7:0] tx_q [$];
  logic [23:0] wr_q [$];
  logic [15:0] re_q [$];
  logic [7:0] mem [int];
  logic [7:0] ref_mem [int];
  int done_cnt = 0, hold_viol = 0;
  int tx_en_cyc = -1, we_cyc = -1, re_cyc = -1, rx_cyc = -1;
  int rd_lat = 0, gap_max = 3;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h2C;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  // UART TX model: busy starts the cycle after tx_en, done pulse ends it.
  int busy_left = 0;
  bit start_pend = 0;
  logic [7:0] tx_cur = 8'h00;
  always @(negedge clk) begin
    bif.tx_done = 1'b0;
    if (rst) begin
      start_pend = 0; busy_left = 0; bif.tx_busy = 1'b0;
    end else if (start_pend) begin
      start_pend = 0; bif.tx_busy = 1'b1; busy_left = $urandom_range(3, 6);
    end else if (bif.tx_busy) begin
      if (bif.tx_data !== tx_cur) hold_viol++;
      busy_left--;
      if (busy_left == 0) begin
        bif.tx_busy = 1'b0; bif.tx_done = 1'b1; done_cnt++;
      end
    end else if (bif.tx_en) begin
      tx_cur = bif.tx_data; tx_q.push_back(bif.tx_data); tx_en_cyc = cyc; start_pend = 1;
    end
  end

  // Register-bus responder: writes land in mem, reads answer after rd_lat
  // cycles (0 = same cycle as bus_re, negative = never).
  int rd_pend = -1;
  logic [15:0] rd_addr = '0;
  always @(negedge clk) begin
    bif.bus_rvalid = 1'b0;
    if (rst) rd_pend = -1;
    else begin
      if (bif.bus_we) begin
        wr_q.push_back({bif.bus_addr, bif.bus_wdata});
        mem[int'(bif.bus_addr)] = bif.bus_wdata; we_cyc = cyc;
      end
      if (bif.bus_re) begin
        re_q.push_back(bif.bus_addr); re_cyc = cyc; rd_addr = bif.bus_addr; rd_pend = rd_lat;
      end
      if (rd_pend == 0) begin
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = mem.exists(int'(rd_addr)) ? mem[int'(rd_addr)] : init_val(rd_addr);
        rd_pend = -1;
      end else if (rd_pend > 0) rd_pend--;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bif.rx_data = b; bif.rx_done = 1'b1; rx_cyc = cyc;
    @(negedge clk);
    bif.rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done(input int dn0, input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > dn0) begin got = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // One command through the link; kind 0=write, 1=read, 2=bad opcode (d).
  task automatic run_cmd(input int kind, input logic [15:0] a, input logic [7:0] d,
                         input int lat, input string tag);
    int tx0, we0, re0, dn0;
    logic [7:0] exp_rsp;
    bit got;
    tx0 = tx_q.size(); we0 = wr_q.size(); re0 = re_q.size(); dn0 = done_cnt;
    rd_lat = lat;
    if (kind == 0) begin
      exp_rsp = C_ACK;
      send_byte(C_W, $urandom_range(0, gap_max));
      send_byte(a[15:8], $urandom_range(0, gap_max));
      send_byte(a[7:0], $urandom_range(0, gap_max));
      send_byte(d, 0);
      ref_mem[int'(a)] = d;
    end else if (kind == 1) begin
      exp_rsp = (lat < 0) ? C_NAK : ref_rd(a);
      send_byte(C_R, $urandom_range(0, gap_max));
      send_byte(a[15:8], $urandom_range(0, gap_max));
      send_byte(a[7:0], 0);
    end else begin
      exp_rsp = C_NAK;
      send_byte(d, 0);
    end
    wait_done(dn0, 400, got);
    checks++;
    if (!got) begin errors++; $display("FAIL %s response: got no tx_done, required one", tag); end
    checks++;
    if (tx_q.size() != tx0 + 1) begin
      errors++; $display("FAIL %s tx count: got %0d, required %0d", tag, tx_q.size() - tx0, 1);
    end else if (tx_q[$] !== exp_rsp) begin
      errors++; $display("FAIL %s tx byte: got %02h, required %02h", tag, tx_q[$], exp_rsp);
    end
    checks++;
    if (wr_q.size() != we0 + (kind == 0 ? 1 : 0)) begin
      errors++; $display("FAIL %s bus_we count: got %0d, required %0d", tag, wr_q.size() - we0, kind == 0);
    end else if (kind == 0 && wr_q[$] !== {a, d}) begin
      errors++; $display("FAIL %s write: got %06h, required %06h", tag, wr_q[$], {a, d});
    end
    checks++;
    if (re_q.size() != re0 + (kind == 1 ? 1 : 0)) begin
      errors++; $display("FAIL %s bus_re count: got %0d, required %0d", tag, re_q.size() - re0, kind == 1);
    end else if (kind == 1 && re_q[$] !== a) begin
      errors++; $display("FAIL %s read addr: got %04h, required %04h", tag, re_q[$], a);
    end
    checks++;
    if (cmd_active !== 1'b0) begin
      errors++; $display("FAIL %s cmd_active after tx_done: got %b, required 0", tag, cmd_active);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({bif.bus_we, bif.bus_re, bif.tx_en, cmd_active} !== 4'b0 ||
        bif.bus_addr !== 16'h0 || bif.bus_wdata !== 8'h0 || bif.tx_data !== 8'h0) begin
      errors++;
      $display("FAIL %s outputs: got we=%b re=%b tx_en=%b act=%b addr=%04h wd=%02h td=%02h, required all 0",
               tag, bif.bus_we, bif.bus_re, bif.tx_en, cmd_active, bif.bus_addr, bif.bus_wdata, bif.tx_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bif.rx_done = 1'b0; bif.rx_data = 8'h00;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("reset");
  endtask

  task automatic test_write();
    run_cmd(0, 16'h1234, 8'hA5, 0, "write");
    checks++;
    if (we_cyc != rx_cyc + 1) begin
      errors++; $display("FAIL write we latency: got %0d, required %0d", we_cyc - rx_cyc, 1);
    end
    checks++;
    if (tx_en_cyc != we_cyc + 1) begin
      errors++; $display("FAIL write tx_en latency: got %0d, required %0d", tx_en_cyc - we_cyc, 1);
    end
  endtask

  task automatic test_read();
    run_cmd(1, 16'h0010, 8'h00, 2, "read");
    checks++;
    if (re_cyc != rx_cyc + 1) begin
      errors++; $display("FAIL read re latency: got %0d, required %0d", re_cyc - rx_cyc, 1);
    end
    checks++;
    if (tx_en_cyc != re_cyc + 3) begin
      errors++; $display("FAIL read tx_en latency: got %0d, required %0d", tx_en_cyc - re_cyc, 3);
    end
    run_cmd(1, 16'h1234, 8'h00, 0, "read_same_cycle");
  endtask

  task automatic test_bad_opcode();
    run_cmd(2, 16'h0000, 8'h41, 0, "bad_op");
    run_cmd(0, 16'h0001, 8'hFF, 0, "after_bad");
  endtask

  task automatic test_timeout();
    int tx0 = tx_q.size(), we0 = wr_q.size(), dn0;
    bit got;
    send_byte(C_W, 0);
    send_byte(8'h12, 30);
    checks++;
    if (cmd_active !== 1'b1) begin
      errors++; $display("FAIL partial cmd_active: got %b, required 1", cmd_active);
    end
    repeat (50) @(negedge clk);
    checks++;
    if (tx_q.size() != tx0 || wr_q.size() != we0 || cmd_active !== 1'b0) begin
      errors++; $display("FAIL addr timeout: got tx=%0d we=%0d act=%b, required 0 0 0",
                         tx_q.size() - tx0, wr_q.size() - we0, cmd_active);
    end
    run_cmd(1, 16'h0002, 8'h00, 1, "after_timeout");
    // Slow but in-time bytes: each gap stays just under the timeout.
    dn0 = done_cnt;
    send_byte(C_W, 60);
    send_byte(8'h00, 60);
    send_byte(8'h07, 60);
    send_byte(8'h33, 0);
    ref_mem[7] = 8'h33;
    wait_done(dn0, 200, got);
    checks++;
    if (!got || tx_q[$] !== C_ACK || wr_q[$] !== 24'h000733) begin
      errors++; $display("FAIL slow write: got done=%b tx=%02h wr=%06h, required 1 06 000733",
                         got, tx_q[$], wr_q[$]);
    end
  endtask

  task automatic test_read_timeout();
    run_cmd(1, 16'h0003, 8'h00, -1, "read_timeout");
    checks++;
    if (tx_en_cyc != re_cyc + TO) begin
      errors++; $display("FAIL read timeout latency: got %0d, required %0d", tx_en_cyc - re_cyc, TO);
    end
  endtask

  task automatic test_drop_and_reset();
    int tx0 = tx_q.size(), we0 = wr_q.size(), dn0 = done_cnt;
    bit got, busy;
    send_byte(C_W, 0); send_byte(8'h00, 0); send_byte(8'h05, 0); send_byte(8'h11, 0);
    ref_mem[5] = 8'h11;
    busy = 0;
    for (int i = 0; i < 100 && !busy; i++) begin
      if (bif.tx_busy === 1'b1) busy = 1; else @(negedge clk);
    end
    send_byte(8'h99, 0);
    wait_done(dn0, 200, got);
    repeat (20) @(negedge clk);
    checks++;
    if (!busy || !got || tx_q.size() != tx0 + 1 || tx_q[$] !== C_ACK || wr_q.size() != we0 + 1) begin
      errors++; $display("FAIL extra byte: got busy=%b done=%b tx=%0d last=%02h we=%0d, required 1 1 1 06 1",
                         busy, got, tx_q.size() - tx0, tx_q[$], wr_q.size() - we0);
    end
    tx0 = tx_q.size(); we0 = wr_q.size();
    send_byte(C_W, 0); send_byte(8'h12, 0); send_byte(8'h34, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("rst_in_data");
    repeat (80) @(negedge clk);
    checks++;
    if (tx_q.size() != tx0 || wr_q.size() != we0) begin
      errors++; $display("FAIL rst abort: got tx=%0d we=%0d, required 0 0", tx_q.size() - tx0, wr_q.size() - we0);
    end
    run_cmd(1, 16'h0005, 8'h00, 1, "after_rst");
  endtask

  task automatic test_back_to_back();
    gap_max = 0;
    run_cmd(0, 16'h0004, 8'h5E, 0, "b2b_wr");
    run_cmd(1, 16'h0004, 8'h00, 0, "b2b_rd");
    run_cmd(2, 16'h0000, 8'hFF, 0, "b2b_bad");
    gap_max = 3;
  endtask

  task automatic test_random();
    int kind, lat;
    logic [15:0] a;
    logic [7:0] d;
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 2);
      a    = 16'($urandom_range(0, 7));
      d    = 8'($urandom_range(0, 255));
      if (kind == 2 && (d == C_W || d == C_R)) d = 8'h00;
      lat  = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 4);
      run_cmd(kind, a, d, lat, "random");
    end
    checks++;
    if (hold_viol != 0) begin
      errors++; $display("FAIL tx_data hold: got %0d changes while busy, required 0", hold_viol);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_timeout();
    test_read_timeout();
    test_drop_and_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
